// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG shift engine: FSM encoding, CMD field positions
// and the fixed TMS walks (LSB is driven first).
package jtag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TAPRST = 3'd1,
        ST_HEAD   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_TAIL   = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam int CMD_HEAD = 0;
    localparam int CMD_TAIL = 1;
    localparam int CMD_IR   = 2;
    localparam int CMD_TRST = 3;

    localparam logic [7:0] TAPRST_TMS  = 8'b0001_1111;
    localparam int         TAPRST_LEN  = 6;
    localparam logic [7:0] DR_HEAD_TMS = 8'b0000_0001;
    localparam int         DR_HEAD_LEN = 3;
    localparam logic [7:0] IR_HEAD_TMS = 8'b0000_0011;
    localparam int         IR_HEAD_LEN = 4;
    localparam logic [7:0] TAIL_TMS    = 8'b0000_0001;
    localparam int         TAIL_LEN    = 2;

endpackage

// File: rtl/jtag_shift_engine_tck_gen.sv
// TCK divider: TCK_DIV FASTCLK cycles per half-period, idles low when disabled.
// rise_o/fall_o mark the cycle whose closing edge moves TCK high/low.
module tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic FASTCLK,
    input  logic RST_B,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW     = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;
    logic          tc;

    assign tc = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en_i) begin
            cnt_d = RELOAD;
            tck_d = 1'b0;
        end else if (tc) begin
            cnt_d = RELOAD;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            cnt_q <= RELOAD;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck_o  = tck_q;
    assign rise_o = tc && !tck_q;
    assign fall_o = tc && tck_q;

endmodule

// File: rtl/jtag_shift_engine.sv
// Multi-chain JTAG shift engine: TAP reset, DR/IR header, shift and trailer walks.
// Define JTAG_TDO_CAPTURE_EN to build the TDO capture path; otherwise RDATA is 0.
//   state  | meaning
//   IDLE   | waiting for START / INITJTAGS
//   TAPRST | TMS 1,1,1,1,1,0
//   HEAD   | RTI -> Shift-DR/IR walk
//   SHIFT  | LEN+1 data bits, LSB first
//   TAIL   | Exit1 -> Update -> RTI walk
//   FINISH | one-cycle DONE, TCK low
module jtag_shift_engine
    import jtag_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NCHAN   = 4,
    parameter  int TCK_DIV = 4,
    localparam int LW      = $clog2(DATA_W),
    localparam int CHW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              FASTCLK,
    input  logic              RST_B,
    input  logic              START,
    input  logic [3:0]        CMD,
    input  logic [LW-1:0]     LEN,
    input  logic [CHW-1:0]    CHAN,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              INITJTAGS,
    input  logic [NCHAN-1:0]  TDO,
    output logic [NCHAN-1:0]  TCK,
    output logic [NCHAN-1:0]  TMS,
    output logic [NCHAN-1:0]  TDI,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [DATA_W-1:0] RDATA
);

    state_e              state_q, state_d;
    logic [LW-1:0]       bit_q, bit_d, last_bit;
    logic                trail_q, ir_q, pend_q, err_q, tms_q, tdi_q;
    logic [LW-1:0]       len_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NCHAN-1:0]    sel_q, chan_oh;
    logic                idle, init_req, take_init, take_cmd;
    logic                e_trail, e_ir;
    logic [LW-1:0]       e_len;
    logic [DATA_W-1:0]   e_wdata;
    logic                tms_d, tdi_d;
    logic                tck_en, tck, tck_rise, tck_fall;

    assign idle      = (state_q == ST_IDLE);
    assign init_req  = INITJTAGS || pend_q;
    assign take_init = idle && init_req;
    assign take_cmd  = idle && START && !init_req;
    assign chan_oh   = NCHAN'(1) << CHAN;
    assign tck_en    = (state_q == ST_TAPRST) || (state_q == ST_HEAD) ||
                       (state_q == ST_SHIFT)  || (state_q == ST_TAIL);

    // On the accepting cycle the first bit is computed from the live inputs.
    assign e_trail = take_cmd ? CMD[CMD_TAIL] : trail_q;
    assign e_ir    = take_cmd ? CMD[CMD_IR]   : ir_q;
    assign e_len   = take_cmd ? LEN           : len_q;
    assign e_wdata = take_cmd ? WDATA         : wdata_q;

    tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .FASTCLK (FASTCLK),
        .RST_B   (RST_B),
        .en_i    (tck_en),
        .tck_o   (tck),
        .rise_o  (tck_rise),
        .fall_o  (tck_fall)
    );

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        last_bit = '0;
        case (state_q)
            ST_TAPRST: last_bit = LW'(TAPRST_LEN - 1);
            ST_HEAD:   last_bit = ir_q ? LW'(IR_HEAD_LEN - 1) : LW'(DR_HEAD_LEN - 1);
            ST_SHIFT:  last_bit = len_q;
            ST_TAIL:   last_bit = LW'(TAIL_LEN - 1);
            default:   last_bit = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                bit_d = '0;
                if (take_init) begin
                    state_d = ST_TAPRST;
                end else if (take_cmd) begin
                    if (CMD[CMD_TRST])      state_d = ST_TAPRST;
                    else if (CMD[CMD_HEAD]) state_d = ST_HEAD;
                    else                    state_d = ST_SHIFT;
                end
            end
            ST_TAPRST, ST_HEAD, ST_SHIFT, ST_TAIL: begin
                if (tck_fall) begin
                    if (bit_q == last_bit) begin
                        bit_d = '0;
                        case (state_q)
                            ST_HEAD:  state_d = ST_SHIFT;
                            ST_SHIFT: state_d = trail_q ? ST_TAIL : ST_FINISH;
                            default:  state_d = ST_FINISH;
                        endcase
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // TMS/TDI are registered from the next state, so they move with TCK's fall.
    always_comb begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        case (state_d)
            ST_TAPRST: tms_d = TAPRST_TMS[bit_d[2:0]];
            ST_HEAD:   tms_d = e_ir ? IR_HEAD_TMS[bit_d[2:0]] : DR_HEAD_TMS[bit_d[2:0]];
            ST_SHIFT: begin
                tms_d = e_trail && (bit_d == e_len);
                tdi_d = e_wdata[bit_d];
            end
            ST_TAIL:   tms_d = TAIL_TMS[bit_d[2:0]];
            default: begin
                tms_d = 1'b0;
                tdi_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            trail_q <= 1'b0;
            ir_q    <= 1'b0;
            len_q   <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            tms_q   <= 1'b0;
            tdi_q   <= 1'b0;
        end else begin
            tms_q <= tms_d;
            tdi_q <= tdi_d;
            err_q <= idle ? (START && init_req) : START;
            if (take_init) begin
                pend_q <= 1'b0;
                sel_q  <= '1;
            end else begin
                if (!idle && INITJTAGS) pend_q <= 1'b1;
                if (take_cmd) begin
                    sel_q   <= chan_oh;
                    trail_q <= CMD[CMD_TAIL];
                    ir_q    <= CMD[CMD_IR];
                    len_q   <= LEN;
                    wdata_q <= WDATA;
                end
            end
        end
    end

`ifdef JTAG_TDO_CAPTURE_EN
    logic [DATA_W-1:0] cap_q, rdata_q;
    logic              tdo_bit;

    assign tdo_bit = |(TDO & sel_q);

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (take_init || take_cmd)
                cap_q <= '0;
            else if (tck_rise && state_q == ST_SHIFT)
                cap_q[bit_q] <= tdo_bit;
            if (state_d == ST_FINISH && state_q != ST_FINISH)
                rdata_q <= cap_q;
        end
    end

    assign RDATA = rdata_q;
`else
    logic unused_tdo;
    assign unused_tdo = ^{TDO, tck_rise};
    assign RDATA      = '0;
`endif

    always_comb begin
        BUSY = (state_q != ST_IDLE);
        DONE = (state_q == ST_FINISH);
        ERR  = err_q;
        TCK  = sel_q & {NCHAN{tck}};
        TMS  = sel_q & {NCHAN{tms_q}};
        TDI  = sel_q & {NCHAN{tdi_q}};
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed + random bench for jtag_shift_engine with a TCK-edge monitor and a
// rule-based expected-waveform model; honours JTAG_TDO_CAPTURE_EN.
module tb_jtag_shift_engine;

    localparam int DW  = 32;
    localparam int NC  = 4;
    localparam int TD  = 4;
    localparam int LW  = $clog2(DW);
    localparam int CHW = 2;
    localparam int BOUND = 3000;

    logic          FASTCLK = 1'b0;
    logic          RST_B = 1'b1, START = 1'b0, INITJTAGS = 1'b0;
    logic [3:0]    CMD = '0;
    logic [LW-1:0] LEN = '0;
    logic [CHW-1:0] CHAN = '0;
    logic [DW-1:0] WDATA = '0;
    logic [NC-1:0] TDO, TCK, TMS, TDI;
    logic          BUSY, DONE, ERR;
    logic [DW-1:0] RDATA;
    logic          tdo_x = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    jtag_shift_engine #(.DATA_W(DW), .NCHAN(NC), .TCK_DIV(TD)) dut (
        .FASTCLK(FASTCLK), .RST_B(RST_B), .START(START), .CMD(CMD), .LEN(LEN),
        .CHAN(CHAN), .WDATA(WDATA), .INITJTAGS(INITJTAGS), .TDO(TDO),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .RDATA(RDATA)
    );

    always #5 FASTCLK = ~FASTCLK;

    // Loopback chain: TDO mirrors TDI, optionally inverted.
    assign TDO = TDI ^ {NC{tdo_x}};

    // Edge monitor: per-channel TMS/TDI at each TCK rise, half-period and stability checks.
    logic          mon_clr = 1'b1;
    logic [127:0]  tms_v [NC];
    logic [127:0]  tdi_v [NC];
    int            nrise [NC];
    int            hi_cnt [NC];
    int            lo_cnt [NC];
    logic [NC-1:0] nz, tck_pv, tms_pv, tdi_pv;
    int            viol, ndone, nerr;

    always @(negedge FASTCLK) begin
        if (mon_clr) begin
            for (int c = 0; c < NC; c++) begin
                tms_v[c] = '0; tdi_v[c] = '0; nrise[c] = 0; hi_cnt[c] = 0; lo_cnt[c] = 0;
            end
            nz = '0; tck_pv = TCK; tms_pv = TMS; tdi_pv = TDI;
            viol = 0; ndone = 0; nerr = 0;
        end else begin
            if (DONE) begin
                ndone++;
                if ((tck_pv & ~TCK) == '0) viol++;
            end
            if (ERR) nerr++;
            for (int c = 0; c < NC; c++) begin
                if (TMS[c] || TDI[c]) nz[c] = 1'b1;
                if (TCK[c] && !tck_pv[c]) begin
                    if (nrise[c] > 0 && lo_cnt[c] != TD) viol++;
                    if (nrise[c] < 128) begin
                        tms_v[c][nrise[c]] = TMS[c];
                        tdi_v[c][nrise[c]] = TDI[c];
                    end
                    nrise[c]++;
                    hi_cnt[c] = 1;
                end else if (TCK[c]) begin
                    hi_cnt[c]++;
                    if (TMS[c] != tms_pv[c] || TDI[c] != tdi_pv[c]) viol++;
                end else if (tck_pv[c]) begin
                    if (hi_cnt[c] != TD) viol++;
                    lo_cnt[c] = 1;
                end else begin
                    lo_cnt[c]++;
                end
            end
            tck_pv = TCK; tms_pv = TMS; tdi_pv = TDI;
        end
    end

    task automatic step();
        @(negedge FASTCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    // Expected per-TCK TMS/TDI bit streams and RDATA, straight from the command rules.
    function automatic void model(input logic [3:0] cmd, input int len, input logic [DW-1:0] wd,
                                  input logic x, output logic [127:0] tms,
                                  output logic [127:0] tdi, output int n,
                                  output logic [DW-1:0] rd);
        int hl;
        tms = '0; tdi = '0; n = 0; rd = '0;
        if (cmd[3]) begin
            for (int i = 0; i < 6; i++) begin tms[n] = (i < 5); n++; end
        end else begin
            if (cmd[0]) begin
                hl = cmd[2] ? 4 : 3;
                for (int i = 0; i < hl; i++) begin
                    tms[n] = cmd[2] ? (i < 2) : (i == 0);
                    n++;
                end
            end
            for (int i = 0; i <= len; i++) begin
                tms[n] = cmd[1] && (i == len);
                tdi[n] = wd[i];
                rd[i]  = wd[i] ^ x;
                n++;
            end
            if (cmd[1]) begin
                tms[n] = 1'b1; n++;
                tms[n] = 1'b0; n++;
            end
        end
`ifndef JTAG_TDO_CAPTURE_EN
        rd = '0;
`endif
    endfunction

    task automatic issue(input logic [3:0] cmd, input int len, input int chan, input logic [DW-1:0] wd);
        CMD = cmd; LEN = LW'(len); CHAN = CHW'(chan); WDATA = wd;
        START = 1'b1;
        step();
        START = 1'b0;
        CMD = 4'($urandom); LEN = LW'($urandom); CHAN = CHW'($urandom); WDATA = DW'($urandom);
        chk("busy_rise", BUSY, 1);
    endtask

    task automatic wait_done(input int coll_at, input int init_at);
        int   n;
        logic busy_ok;
        n = 0; busy_ok = 1'b1;
        while (DONE !== 1'b1 && n < BOUND) begin
            if (BUSY !== 1'b1) busy_ok = 1'b0;
            START     = (n == coll_at);
            INITJTAGS = (n == init_at);
            if (n == coll_at) begin
                CMD = 4'($urandom); LEN = LW'($urandom); CHAN = CHW'($urandom); WDATA = DW'($urandom);
            end
            step();
            n++;
        end
        START = 1'b0; INITJTAGS = 1'b0;
        chk("done_within_bound", n < BOUND, 1);
        chk("busy_during_op", busy_ok, 1);
        step();
        chk("busy_after_done", BUSY, 0);
    endtask

    task automatic check_op(input string tag, input logic [NC-1:0] sel, input logic [3:0] cmd,
                            input int len, input logic [DW-1:0] wd, input logic x, input int exp_err);
        logic [127:0]  etms, etdi;
        int            en;
        logic [DW-1:0] erd;
        model(cmd, len, wd, x, etms, etdi, en, erd);
        for (int c = 0; c < NC; c++) begin
            if (sel[c]) begin
                chk({tag, "_ntck"}, nrise[c], en);
                chk({tag, "_tms"}, tms_v[c], etms);
                chk({tag, "_tdi"}, tdi_v[c], etdi);
            end else begin
                chk({tag, "_idle_chan_tck"}, nrise[c], 0);
                chk({tag, "_idle_chan_drive"}, nz[c], 0);
            end
        end
        chk({tag, "_timing"}, viol, 0);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_err_count"}, nerr, exp_err);
        chk({tag, "_rdata"}, RDATA, erd);
    endtask

    task automatic do_op(input string tag, input logic [3:0] cmd, input int len, input int chan,
                         input logic [DW-1:0] wd, input logic x, input int coll_at);
        tdo_x = x;
        clear_mon();
        issue(cmd, len, chan, wd);
        wait_done(coll_at, -1);
        check_op(tag, NC'(1) << chan, cmd, len, wd, x, (coll_at >= 0) ? 1 : 0);
    endtask

    logic [3:0]    rc;
    logic [DW-1:0] rw;
    int            w;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish (observed hang, required completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 RST_B = 1'b0;
        step(); step();
        chk("rst_tck", TCK, 0);
        chk("rst_tms", TMS, 0);
        chk("rst_tdi", TDI, 0);
        chk("rst_flags", {BUSY, DONE, ERR}, 0);
        chk("rst_rdata", RDATA, 0);
        RST_B = 1'b1;
        step();

        do_op("loopback", 4'b0011, 15, 2, 32'h0000_A5C3, 1'b0, -1);
        chk("loopback_21tck", nrise[2], 21);
        do_op("ir_header", 4'b0111, 4, 0, 32'h0000_001B, 1'b0, -1);
        chk("ir_11tck", nrise[0], 11);
        do_op("len0_shift", 4'b0000, 0, 3, 32'h0000_0001, 1'b1, -1);
        do_op("len_max", 4'b0011, DW - 1, 1, 32'h9E37_79B9, 1'b1, -1);

        // INITJTAGS in IDLE: every chain walks to Test-Logic-Reset and back.
        clear_mon();
        INITJTAGS = 1'b1; step(); INITJTAGS = 1'b0;
        chk("init_busy_rise", BUSY, 1);
        wait_done(-1, -1);
        check_op("initjtags", '1, 4'b1000, 0, '0, 1'b0, 0);

        do_op("collision", 4'b0101, 9, 1, 32'h0000_0355, 1'b0, 30);

        // START and INITJTAGS together: TAP reset on all chains wins.
        clear_mon();
        CMD = 4'b0011; LEN = LW'(7); CHAN = 2'd1; WDATA = 32'hFF;
        START = 1'b1; INITJTAGS = 1'b1; step(); START = 1'b0; INITJTAGS = 1'b0;
        wait_done(-1, -1);
        check_op("start_init_same", '1, 4'b1000, 0, '0, 1'b0, 1);

        // INITJTAGS while busy is serviced right after the running shift.
        tdo_x = 1'b0;
        clear_mon();
        issue(4'b0001, 5, 3, 32'h0000_002D);
        wait_done(-1, 20);
        check_op("pend_first", 4'b1000, 4'b0001, 5, 32'h0000_002D, 1'b0, 0);
        clear_mon();
        chk("pend_busy", BUSY, 1);
        wait_done(-1, -1);
        check_op("pend_taprst", '1, 4'b1000, 0, '0, 1'b0, 0);

        // Reset in the middle of a long shift.
        do_op("pre_reset", 4'b0000, 11, 1, 32'h0000_0ABC, 1'b1, -1);
        tdo_x = 1'b0;
        clear_mon();
        issue(4'b0000, DW - 1, 1, 32'hDEAD_BEEF);
        w = 0;
        while (nrise[1] < 5 && w < 1000) begin step(); w++; end
        chk("rst_reach_shift", w < 1000, 1);
        RST_B = 1'b0;
        #1;
        chk("midrst_tck", TCK, 0);
        chk("midrst_tms", TMS, 0);
        chk("midrst_tdi", TDI, 0);
        chk("midrst_flags", {BUSY, DONE, ERR}, 0);
        chk("midrst_rdata", RDATA, 0);
        step(); step(); step();
        RST_B = 1'b1;
        clear_mon();
        repeat (40) step();
        chk("midrst_no_done", ndone, 0);
        chk("midrst_no_tck", nrise[1], 0);
        do_op("post_reset", 4'b0011, 15, 2, 32'h0000_A5C3, 1'b0, -1);

        for (int k = 0; k < 20; k++) begin
            rc = 4'($urandom);
            if (rc[3] && $urandom_range(0, 3) != 0) rc[3] = 1'b0;
            rw = DW'($urandom);
            do_op("random", rc, $urandom_range(0, DW - 1), $urandom_range(0, NC - 1), rw,
                  1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
